// File: rtl/mem_access_unit.sv
// Single-entry load/store unit: address generation, dmem request, load alignment, writeback pulse.
// Define MEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as exceptions.
module mem_access_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PRF_IDX_W = 6,
  parameter int unsigned ROB_IDX_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic                 in_is_store,
  input  logic [1:0]           in_size,
  input  logic                 in_unsigned,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [PRF_IDX_W-1:0] in_rd_index,
  input  logic [ROB_IDX_W-1:0] in_rob_index,
  output logic                 busy,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic [XLEN-1:0]      dmem_req_addr,
  output logic                 dmem_req_we,
  output logic [XLEN-1:0]      dmem_req_wdata,
  output logic [3:0]           dmem_req_wstrb,
  input  logic                 dmem_resp_valid,
  input  logic [XLEN-1:0]      dmem_resp_rdata,
  output logic                 wb_valid,
  output logic                 wb_rd_write,
  output logic [PRF_IDX_W-1:0] wb_rd_index,
  output logic [XLEN-1:0]      wb_data,
  output logic [ROB_IDX_W-1:0] wb_rob_index,
  output logic                 wb_exception
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  state_e                 state;
  logic                   op_store;
  logic                   op_unsigned;
  logic [1:0]             op_size;
  logic [PRF_IDX_W-1:0]   op_rd;
  logic [ROB_IDX_W-1:0]   op_rob;

  logic [XLEN-1:0]        acc_addr;
  logic [XLEN-1:0]        acc_wdata;
  logic [3:0]             acc_wstrb;
  logic                   acc_misalign;

  logic [1:0]             ld_off;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [XLEN-1:0]        ld_data;

  assign busy     = (state != StIdle);
  assign acc_addr = in_rs1_data + in_imm;

`ifdef MEM_MISALIGN_TRAP_EN
  assign acc_misalign = ((in_size == 2'd1) && acc_addr[0]) ||
                        (in_size[1] && (acc_addr[1:0] != 2'b00));
`else
  assign acc_misalign = 1'b0;
`endif

  // Store data is replicated across lanes so the strobes alone select the bytes written.
  always_comb begin
    acc_wdata = in_rs2_data;
    acc_wstrb = 4'b1111;
    unique case (in_size)
      2'd0: begin
        acc_wdata = {4{in_rs2_data[7:0]}};
        acc_wstrb = 4'b0001 << acc_addr[1:0];
      end
      2'd1: begin
        acc_wdata = {2{in_rs2_data[15:0]}};
        acc_wstrb = 4'b0011 << {acc_addr[1], 1'b0};
      end
      default: begin
        acc_wdata = in_rs2_data;
        acc_wstrb = 4'b1111;
      end
    endcase
  end

  assign ld_off  = dmem_req_addr[1:0];
  assign ld_byte = dmem_resp_rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = dmem_resp_rdata[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = dmem_resp_rdata;
    unique case (op_size)
      2'd0:    ld_data = {{(XLEN-8){ld_byte[7] & ~op_unsigned}}, ld_byte};
      2'd1:    ld_data = {{(XLEN-16){ld_half[15] & ~op_unsigned}}, ld_half};
      default: ld_data = dmem_resp_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= StIdle;
      op_store       <= 1'b0;
      op_unsigned    <= 1'b0;
      op_size        <= 2'd0;
      op_rd          <= '0;
      op_rob         <= '0;
      dmem_req_valid <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_we    <= 1'b0;
      dmem_req_wdata <= '0;
      dmem_req_wstrb <= 4'b0000;
      wb_valid       <= 1'b0;
      wb_rd_write    <= 1'b0;
      wb_rd_index    <= '0;
      wb_data        <= '0;
      wb_rob_index   <= '0;
      wb_exception   <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_exception <= 1'b0;
      case (state)
        StIdle: begin
          if (in_valid && !clear) begin
            op_store      <= in_is_store;
            op_unsigned   <= in_unsigned;
            op_size       <= in_size;
            op_rd         <= in_rd_index;
            op_rob        <= in_rob_index;
            dmem_req_addr <= acc_addr;
            if (acc_misalign) begin
              wb_valid     <= 1'b1;
              wb_exception <= 1'b1;
              wb_rd_write  <= 1'b0;
              wb_rd_index  <= in_rd_index;
              wb_data      <= acc_addr;
              wb_rob_index <= in_rob_index;
            end else begin
              state          <= StReq;
              dmem_req_valid <= 1'b1;
              dmem_req_we    <= in_is_store;
              dmem_req_wdata <= in_is_store ? acc_wdata : '0;
              dmem_req_wstrb <= in_is_store ? acc_wstrb : 4'b0000;
            end
          end
        end
        StReq: begin
          if (clear) begin
            state          <= StIdle;
            dmem_req_valid <= 1'b0;
          end else if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            if (op_store) begin
              state        <= StIdle;
              wb_valid     <= 1'b1;
              wb_rd_write  <= 1'b0;
              wb_rd_index  <= op_rd;
              wb_data      <= '0;
              wb_rob_index <= op_rob;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          if (dmem_resp_valid) begin
            state <= StIdle;
            if (!clear) begin
              wb_valid     <= 1'b1;
              wb_rd_write  <= 1'b1;
              wb_rd_index  <= op_rd;
              wb_data      <= ld_data;
              wb_rob_index <= op_rob;
            end
          end else if (clear) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          // The flushed load's response is still owed by memory; absorb it silently.
          if (dmem_resp_valid) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model checked every cycle plus literal expectations.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset, clear, in_valid, in_is_store, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic [5:0]  in_rd_index;
  logic [4:0]  in_rob_index;
  logic        busy, dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_resp_rdata, wb_data;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_resp_valid, wb_valid, wb_rd_write, wb_exception;
  logic [5:0]  wb_rd_index;
  logic [4:0]  wb_rob_index;

  int errors = 0;
  int checks = 0;
  bit run_checks = 0;

  mem_access_unit dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_is_store(in_is_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rd_index(in_rd_index), .in_rob_index(in_rob_index), .busy(busy),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_rd_write(wb_rd_write), .wb_rd_index(wb_rd_index),
    .wb_data(wb_data), .wb_rob_index(wb_rob_index), .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // First byte lane of the access: offset rounded down to the access size.
  function automatic int lane_start(input logic [31:0] a, input int n);
    return (int'(a % 32'd4) / n) * n;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rdata);
    int n = nbytes(sz);
    int s = lane_start(a, n);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    logic [31:0] v = (rdata >> (8 * s)) & mask;
    if (!uns && n < 4 && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] rs2);
    int n = nbytes(sz);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int s = lane_start(a, n);
    logic [3:0] st = '0;
    for (int i = 0; i < 4; i++) if (i >= s && i < s + n) st[i] = 1'b1;
    return st;
  endfunction

  function automatic bit model_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (a % nbytes(sz)) != 0;
`else
    return (sz == 2'd3) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // occupied / request outstanding / response owed / response owed but flushed
  bit          m_busy = 0, m_req = 0, m_flush = 0;
  logic        m_store = 0, m_uns = 0, m_we = 0;
  logic [1:0]  m_size = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_wstrb = 0;
  logic [5:0]  m_rd = 0;
  logic [4:0]  m_rob = 0;
  bit          e_wb = 0;
  logic        e_rd_write = 0, e_exc = 0;
  logic [31:0] e_data = 0;
  logic [5:0]  e_rd = 0;
  logic [4:0]  e_rob = 0;

  always @(posedge clock) begin
    logic [31:0] a;
    e_wb = 0;
    if (reset) begin
      m_busy = 0; m_req = 0; m_flush = 0;
    end else if (!m_busy) begin
      if (in_valid && !clear) begin
        a = in_rs1_data + in_imm;
        if (model_trap(in_size, a)) begin
          e_wb = 1; e_exc = 1; e_rd_write = 0; e_data = a; e_rob = in_rob_index;
        end else begin
          m_busy = 1; m_req = 1; m_flush = 0;
          m_store = in_is_store; m_size = in_size; m_uns = in_unsigned; m_addr = a;
          m_rd = in_rd_index; m_rob = in_rob_index; m_we = in_is_store;
          m_wdata = in_is_store ? model_wdata(in_size, in_rs2_data) : 32'h0;
          m_wstrb = in_is_store ? model_wstrb(in_size, a) : 4'h0;
        end
      end
    end else if (m_req) begin
      if (clear) begin
        m_busy = 0; m_req = 0;
      end else if (dmem_req_ready) begin
        m_req = 0;
        if (m_store) begin
          m_busy = 0; e_wb = 1; e_exc = 0; e_rd_write = 0; e_data = 0; e_rob = m_rob;
        end
      end
    end else begin
      if (dmem_resp_valid) begin
        m_busy = 0;
        if (!m_flush && !clear) begin
          e_wb = 1; e_exc = 0; e_rd_write = 1; e_rd = m_rd; e_rob = m_rob;
          e_data = model_load(m_size, m_uns, m_addr, dmem_resp_rdata);
        end
        m_flush = 0;
      end else if (clear) begin
        m_flush = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (run_checks) begin
      chk("busy", busy, m_busy);
      chk("req_valid", dmem_req_valid, m_req);
      chk("wb_valid", wb_valid, e_wb);
      if (m_req) begin
        chk("req_addr", dmem_req_addr, m_addr);
        chk("req_we", dmem_req_we, m_we);
        chk("req_wdata", dmem_req_wdata, m_wdata);
        chk("req_wstrb", dmem_req_wstrb, m_wstrb);
      end
      if (e_wb) begin
        chk("wb_rd_write", wb_rd_write, e_rd_write);
        chk("wb_exception", wb_exception, e_exc);
        chk("wb_rob", wb_rob_index, e_rob);
        chk("wb_data", wb_data, e_data);
        if (e_rd_write) chk("wb_rd_index", wb_rd_index, e_rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clock);
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [5:0] rd, input logic [4:0] rob);
    in_valid = 1; in_is_store = st; in_size = sz; in_unsigned = un;
    in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm; in_rd_index = rd; in_rob_index = rob;
    step();
    in_valid = 0;
  endtask

  task automatic respond(input logic [31:0] rdata);
    dmem_resp_valid = 1; dmem_resp_rdata = rdata;
    step();
    dmem_resp_valid = 0;
  endtask

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs[6] = '{
    '{2'd0, 1'b0, 32'h601, 32'h1234_F600, 32'hFFFF_FFF6},
    '{2'd0, 1'b1, 32'h602, 32'h00AB_0000, 32'h0000_00AB},
    '{2'd1, 1'b0, 32'h602, 32'h8001_7FFF, 32'hFFFF_8001},
    '{2'd1, 1'b1, 32'h600, 32'h8001_F00F, 32'h0000_F00F},
    '{2'd1, 1'b0, 32'h600, 32'h8001_7FFF, 32'h0000_7FFF},
    '{2'd3, 1'b0, 32'h604, 32'h89AB_CDEF, 32'h89AB_CDEF}
  };

  initial begin
    reset = 1; clear = 0; in_valid = 0; in_is_store = 0; in_size = 0; in_unsigned = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_rd_index = 0; in_rob_index = 0;
    dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_rdata = 0;
    repeat (2) step();
    run_checks = 1;
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", dmem_req_valid, 0);
    chk("rst_we", dmem_req_we, 0);
    chk("rst_wstrb", dmem_req_wstrb, 0);
    chk("rst_addr", dmem_req_addr, 0);
    chk("rst_wdata", dmem_req_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_exc", wb_exception, 0);
    reset = 0;
    step();

    // Store word, ready held high.
    dmem_req_ready = 1;
    issue(1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, 32'h4, 6'd1, 5'd3);
    chk("sw_req_valid", dmem_req_valid, 1);
    chk("sw_addr", dmem_req_addr, 32'h104);
    chk("sw_wstrb", dmem_req_wstrb, 4'b1111);
    chk("sw_we", dmem_req_we, 1);
    chk("sw_wdata", dmem_req_wdata, 32'hDEAD_BEEF);
    step();
    chk("sw_wb_valid", wb_valid, 1);
    chk("sw_rd_write", wb_rd_write, 0);
    chk("sw_busy", busy, 0);
    // Back-to-back store accepted on the wb cycle.
    issue(1, 2'd0, 0, 32'h300, 32'h0000_115A, 32'h1, 6'd2, 5'd4);
    chk("sb_wstrb", dmem_req_wstrb, 4'b0010);
    chk("sb_wdata", dmem_req_wdata, 32'h5A5A_5A5A);
    step();

    // LB / LBU from 0x103.
    for (int u = 0; u < 2; u++) begin
      issue(0, 2'd0, u[0], 32'h100, 0, 32'h3, 6'd7, 5'd5);
      chk("lb_wstrb", dmem_req_wstrb, 0);
      step();
      chk("lb_busy_wait", busy, 1);
      respond(32'h80FF_0011);
      chk("lb_wb_valid", wb_valid, 1);
      chk("lb_wb_data", wb_data, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      chk("lb_rd_index", wb_rd_index, 6'd7);
      step();
    end

    // SH 0xABCD to 0x202.
    issue(1, 2'd1, 0, 32'h200, 32'h0000_ABCD, 32'h2, 6'd0, 5'd6);
    chk("sh_wdata", dmem_req_wdata, 32'hABCD_ABCD);
    chk("sh_wstrb", dmem_req_wstrb, 4'b1100);
    step(); step();

    // LW with ready low for 3 cycles, response 2 cycles after handshake.
    dmem_req_ready = 0;
    issue(0, 2'd2, 0, 32'h400, 0, 32'h10, 6'd9, 5'd7);
    for (int i = 0; i < 3; i++) begin
      chk("lw_stall_addr", dmem_req_addr, 32'h410);
      chk("lw_stall_busy", busy, 1);
      if (i < 2) step();
    end
    dmem_req_ready = 1;
    step();
    chk("lw_after_hs_valid", dmem_req_valid, 0);
    step();
    respond(32'h1234_5678);
    chk("lw_wb_valid", wb_valid, 1);
    chk("lw_wb_data", wb_data, 32'h1234_5678);
    step();
    chk("lw_wb_once", wb_valid, 0);

    // clear in WAIT, response two cycles later, then next uop accepted.
    issue(0, 2'd2, 0, 32'h500, 0, 0, 6'd3, 5'd8);
    step();
    clear = 1;
    step();
    clear = 0;
    step();
    chk("drain_busy", busy, 1);
    respond(32'hFFFF_0000);
    chk("drain_no_wb", wb_valid, 0);
    chk("drain_busy_low", busy, 0);
    issue(1, 2'd2, 0, 32'h500, 32'h55, 0, 6'd0, 5'd9);
    chk("after_drain_req", dmem_req_valid, 1);
    step();

    // clear in REQ while stalled, and clear on the handshake cycle.
    dmem_req_ready = 0;
    issue(0, 2'd2, 0, 32'h700, 0, 0, 6'd4, 5'd10);
    clear = 1; step(); clear = 0;
    dmem_req_ready = 1;
    issue(1, 2'd2, 0, 32'h700, 32'h1, 0, 6'd4, 5'd11);
    clear = 1; step(); clear = 0;
    chk("clr_hs_no_wb", wb_valid, 0);

    // clear together with the response in WAIT; in_valid with clear in IDLE.
    issue(0, 2'd2, 0, 32'h800, 0, 0, 6'd5, 5'd12);
    step();
    clear = 1; respond(32'h1111_2222); clear = 0;
    chk("clr_resp_busy", busy, 0);
    clear = 1;
    issue(0, 2'd2, 0, 32'h800, 0, 0, 6'd5, 5'd13);
    clear = 0;
    chk("clr_idle_no_accept", busy, 0);

    // in_valid while busy is ignored; reset mid-operation.
    dmem_req_ready = 0;
    issue(0, 2'd2, 0, 32'h900, 0, 0, 6'd6, 5'd14);
    issue(1, 2'd0, 0, 32'hA00, 32'h77, 0, 6'd6, 5'd15);
    chk("busy_ignore_addr", dmem_req_addr, 32'h900);
    dmem_req_ready = 1;
    step();
    respond(32'hCAFE_0001);
    reset = 1;
    issue(0, 2'd2, 0, 32'hB00, 0, 0, 6'd1, 5'd1);
    reset = 0;
    chk("rst_mid_busy", busy, 0);

    // Load extraction vectors.
    foreach (vecs[k]) begin
      issue(0, vecs[k].size, vecs[k].uns, 32'h600, 0, vecs[k].addr - 32'h600, 6'd11, 5'd16);
      step();
      respond(vecs[k].rdata);
      chk("vec_wb_data", wb_data, vecs[k].exp);
    end
    step();

    // Misaligned LW at 0x101.
    issue(0, 2'd2, 0, 32'h100, 0, 32'h1, 6'd10, 5'd17);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_no_req", dmem_req_valid, 0);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_exc", wb_exception, 1);
    chk("mis_data", wb_data, 32'h101);
`else
    chk("mis_req", dmem_req_valid, 1);
    chk("mis_addr", dmem_req_addr, 32'h101);
    step();
    respond(32'hCAFE_F00D);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_exc", wb_exception, 0);
    chk("mis_data", wb_data, 32'hCAFE_F00D);
`endif
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
